// File: rtl/tmr_pwm_out.sv
// tmr_pwm_out: turns timer match/overflow pulses into a complementary, dead-time
// protected PWM pair (PWM / toggle / one-shot modes) plus a period postscaler IRQ.
// Latency: event -> raw at +1 edge, outputs/irq at +2 edges, busy at +1 edge; no backpressure.
// Ports: tmr_clk/sys_rst_n clock and async active-low reset; en/mode/pol/dt_val/postscale
//        configuration; arm + match0/match1/ovf event pulses in; pwm_out_h/l, period_irq, busy out.
module tmr_pwm_out #(
    parameter int DT_W = 8,
    parameter int PS_W = 8
) (
    input  logic            tmr_clk,
    input  logic            sys_rst_n,
    input  logic            en,
    input  logic [1:0]      mode,
    input  logic            pol,
    input  logic [DT_W-1:0] dt_val,
    input  logic [PS_W-1:0] postscale,
    input  logic            arm,
    input  logic            match0_event,
    input  logic            match1_event,
    input  logic            ovf_event,
    output logic            pwm_out_h,
    output logic            pwm_out_l,
    output logic            period_irq,
    output logic            busy
);

    typedef enum logic [1:0] {
        OS_IDLE   = 2'd0,
        OS_ARMED  = 2'd1,
        OS_ACTIVE = 2'd2,
        OS_DONE   = 2'd3
    } os_state_t;

    localparam logic [1:0] MODE_OFF = 2'b00;
    localparam logic [1:0] MODE_PWM = 2'b01;
    localparam logic [1:0] MODE_TOG = 2'b10;

    logic [1:0]      mode_q;
    logic            init_q;
    logic            raw_q, raw_d;
    os_state_t       st_q, st_d;
    logic [DT_W-1:0] dt_cnt_q, dt_cnt_d;
    logic [PS_W-1:0] ps_cnt_q, ps_cnt_d;
    logic            irq_pre_q, irq_pre_d;
    logic            irq_q, irq_d;
    logic            pwm_h_q, pwm_h_d;
    logic            pwm_l_q, pwm_l_d;
    logic            busy_q, busy_d;
    logic            force_idle;

    // init_q makes the first edge after reset release an idle edge, so the
    // outputs move from the reset value 0 to the inactive level (pol).
    assign force_idle = !en || (mode != mode_q) || !init_q;

    always_comb begin
        raw_d     = raw_q;
        st_d      = st_q;
        ps_cnt_d  = ps_cnt_q;
        irq_pre_d = 1'b0;
        dt_cnt_d  = dt_cnt_q;

        case (mode)
            MODE_OFF: raw_d = 1'b0;
            MODE_PWM: begin
                // clear has priority: simultaneous set/clear gives 0% duty
                if (match1_event)      raw_d = 1'b0;
                else if (match0_event) raw_d = 1'b1;
            end
            MODE_TOG: begin
                if (match0_event) raw_d = !raw_q;
            end
            default: begin
                case (st_q)
                    OS_IDLE, OS_DONE: begin
                        if (arm) st_d = OS_ARMED;
                    end
                    OS_ARMED: begin
                        if (match0_event) begin
                            if (match1_event) begin
                                st_d      = OS_DONE;
                                irq_pre_d = 1'b1;
                            end else begin
                                st_d  = OS_ACTIVE;
                                raw_d = 1'b1;
                            end
                        end
                    end
                    OS_ACTIVE: begin
                        // ovf acts as a timeout when no match1 ends the pulse
                        if (match1_event || ovf_event) begin
                            st_d      = OS_DONE;
                            raw_d     = 1'b0;
                            irq_pre_d = 1'b1;
                        end
                    end
                    default: st_d = OS_IDLE;
                endcase
            end
        endcase

        if ((mode == MODE_PWM || mode == MODE_TOG) && match0_event) begin
            if (ps_cnt_q == postscale) begin
                ps_cnt_d  = '0;
                irq_pre_d = 1'b1;
            end else begin
                ps_cnt_d = ps_cnt_q + 1'b1;
            end
        end

        // every raw edge (re)starts the dead band; dt_val is only sampled here
        if (raw_d != raw_q)       dt_cnt_d = dt_val;
        else if (dt_cnt_q != '0)  dt_cnt_d = dt_cnt_q - 1'b1;

        pwm_h_d = pol ^ (raw_q & (dt_cnt_q == '0));
        pwm_l_d = pol ^ (!raw_q & (dt_cnt_q == '0));
        irq_d   = irq_pre_q;

        if (force_idle) begin
            raw_d     = 1'b0;
            st_d      = OS_IDLE;
            ps_cnt_d  = '0;
            dt_cnt_d  = '0;
            irq_pre_d = 1'b0;
            irq_d     = 1'b0;
            pwm_h_d   = pol;
            pwm_l_d   = pol;
        end

        busy_d = (st_d == OS_ARMED) || (st_d == OS_ACTIVE);
    end

    always_ff @(posedge tmr_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_q    <= 2'b00;
            init_q    <= 1'b0;
            raw_q     <= 1'b0;
            st_q      <= OS_IDLE;
            dt_cnt_q  <= '0;
            ps_cnt_q  <= '0;
            irq_pre_q <= 1'b0;
            irq_q     <= 1'b0;
            pwm_h_q   <= 1'b0;
            pwm_l_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            mode_q    <= mode;
            init_q    <= 1'b1;
            raw_q     <= raw_d;
            st_q      <= st_d;
            dt_cnt_q  <= dt_cnt_d;
            ps_cnt_q  <= ps_cnt_d;
            irq_pre_q <= irq_pre_d;
            irq_q     <= irq_d;
            pwm_h_q   <= pwm_h_d;
            pwm_l_q   <= pwm_l_d;
            busy_q    <= busy_d;
        end
    end

    assign pwm_out_h  = pwm_h_q;
    assign pwm_out_l  = pwm_l_q;
    assign period_irq = irq_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_tmr_pwm_out.sv
// tb_tmr_pwm_out: scoreboard bench for tmr_pwm_out; per-cycle stimulus and
// expected outputs are queued per scenario, then popped and compared cycle by cycle.
// Outputs are sampled 1 time unit after each rising edge.
module tb_tmr_pwm_out;

    logic       tmr_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       pol = 1'b0;
    logic [7:0] dt_val = 8'd0;
    logic [7:0] postscale = 8'd0;
    logic       arm = 1'b0;
    logic       match0_event = 1'b0;
    logic       match1_event = 1'b0;
    logic       ovf_event = 1'b0;
    logic       pwm_out_h, pwm_out_l, period_irq, busy;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic m0, m1, ovf, arm, en;
    } stim_t;

    typedef struct {
        logic h, l, irq, busy, skip;
    } exp_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];

    tmr_pwm_out #(.DT_W(8), .PS_W(8)) dut (
        .tmr_clk(tmr_clk), .sys_rst_n(sys_rst_n), .en(en), .mode(mode), .pol(pol),
        .dt_val(dt_val), .postscale(postscale), .arm(arm),
        .match0_event(match0_event), .match1_event(match1_event), .ovf_event(ovf_event),
        .pwm_out_h(pwm_out_h), .pwm_out_l(pwm_out_l), .period_irq(period_irq), .busy(busy)
    );

    always #5 tmr_clk = ~tmr_clk;

    task automatic tick();
        @(posedge tmr_clk);
        #1;
    endtask

    task automatic drive(input stim_t s);
        match0_event = s.m0;
        match1_event = s.m1;
        ovf_event    = s.ovf;
        arm          = s.arm;
        en           = s.en;
    endtask

    // Park the block idle, apply a configuration and let it settle with raw = 0.
    task automatic setup(input logic [1:0] m, input logic p, input logic [7:0] d, input logic [7:0] ps);
        drive(stim_t'{m0: 1'b0, m1: 1'b0, ovf: 1'b0, arm: 1'b0, en: 1'b0});
        tick(); tick();
        mode = m; pol = p; dt_val = d; postscale = ps; en = 1'b1;
        tick(); tick(); tick();
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({pwm_out_h, pwm_out_l, period_irq, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_values got=%b exp=0000", {pwm_out_h, pwm_out_l, period_irq, busy});
        end
        en = 1'b1; mode = 2'b01; pol = 1'b1;
        #10 sys_rst_n = 1'b1;
        tick();
        checks++;
        if ({pwm_out_h, pwm_out_l, period_irq, busy} !== 4'b1100) begin
            failures++;
            $display("FAIL reset_first_edge got=%b exp=1100", {pwm_out_h, pwm_out_l, period_irq, busy});
        end
        tick(); tick();
        checks++;
        if ({pwm_out_h, pwm_out_l} !== 2'b10) begin
            failures++;
            $display("FAIL reset_settled_low_side got=%b exp=10", {pwm_out_h, pwm_out_l});
        end
    endtask

    task automatic test_pwm(input logic [7:0] d);
        setup(2'b01, 1'b0, d, 8'd0);
        for (int c = 0; c < 24; c++) begin
            stim_q.push_back(stim_t'{m0: c == 10, m1: c == 14, ovf: 1'b0, arm: 1'b0, en: 1'b1});
            exp_q.push_back(exp_t'{h: (c >= 12 + int'(d)) && (c <= 15), l: (c < 12) || (c >= 16 + int'(d)),
                                   irq: c == 12, busy: 1'b0, skip: 1'b0});
        end
        for (int c = 0; exp_q.size() != 0; c++) begin
            exp_t e; stim_t s;
            e = exp_q.pop_front(); s = stim_q.pop_front();
            checks++;
            if ({pwm_out_h, pwm_out_l, period_irq, busy} !== {e.h, e.l, e.irq, e.busy}) begin
                failures++;
                $display("FAIL pwm_dt%0d cyc=%0d h,l,irq,busy got=%b exp=%b", d, c,
                         {pwm_out_h, pwm_out_l, period_irq, busy}, {e.h, e.l, e.irq, e.busy});
            end
            drive(s); tick();
        end
    endtask

    task automatic test_polarity_zero_duty();
        setup(2'b01, 1'b1, 8'd0, 8'd0);
        for (int c = 0; c < 12; c++) begin
            stim_q.push_back(stim_t'{m0: c == 5, m1: c == 5, ovf: 1'b0, arm: 1'b0, en: 1'b1});
            exp_q.push_back(exp_t'{h: 1'b1, l: 1'b0, irq: c == 7, busy: 1'b0, skip: 1'b0});
        end
        for (int c = 0; exp_q.size() != 0; c++) begin
            exp_t e; stim_t s;
            e = exp_q.pop_front(); s = stim_q.pop_front();
            checks++;
            if ({pwm_out_h, pwm_out_l, period_irq, busy} !== {e.h, e.l, e.irq, e.busy}) begin
                failures++;
                $display("FAIL pol_zero_duty cyc=%0d h,l,irq,busy got=%b exp=%b", c,
                         {pwm_out_h, pwm_out_l, period_irq, busy}, {e.h, e.l, e.irq, e.busy});
            end
            drive(s); tick();
        end
    endtask

    task automatic test_postscaler();
        setup(2'b01, 1'b0, 8'd0, 8'd2);
        for (int c = 0; c < 22; c++) begin
            stim_q.push_back(stim_t'{m0: (c >= 2) && (c <= 17) && ((c - 2) % 3 == 0), m1: 1'b0, ovf: 1'b0,
                                     arm: 1'b0, en: 1'b1});
            exp_q.push_back(exp_t'{h: c >= 4, l: c < 4, irq: (c == 10) || (c == 19), busy: 1'b0, skip: 1'b0});
        end
        for (int c = 0; exp_q.size() != 0; c++) begin
            exp_t e; stim_t s;
            e = exp_q.pop_front(); s = stim_q.pop_front();
            checks++;
            if ({pwm_out_h, pwm_out_l, period_irq, busy} !== {e.h, e.l, e.irq, e.busy}) begin
                failures++;
                $display("FAIL postscaler cyc=%0d h,l,irq,busy got=%b exp=%b", c,
                         {pwm_out_h, pwm_out_l, period_irq, busy}, {e.h, e.l, e.irq, e.busy});
            end
            drive(s); tick();
        end
    endtask

    task automatic test_toggle();
        setup(2'b10, 1'b0, 8'd0, 8'd0);
        for (int c = 0; c < 14; c++) begin
            stim_q.push_back(stim_t'{m0: (c == 3) || (c == 8), m1: c == 5, ovf: c == 6, arm: 1'b0, en: 1'b1});
            exp_q.push_back(exp_t'{h: (c >= 5) && (c <= 9), l: (c < 5) || (c >= 10),
                                   irq: (c == 5) || (c == 10), busy: 1'b0, skip: 1'b0});
        end
        for (int c = 0; exp_q.size() != 0; c++) begin
            exp_t e; stim_t s;
            e = exp_q.pop_front(); s = stim_q.pop_front();
            checks++;
            if ({pwm_out_h, pwm_out_l, period_irq, busy} !== {e.h, e.l, e.irq, e.busy}) begin
                failures++;
                $display("FAIL toggle cyc=%0d h,l,irq,busy got=%b exp=%b", c,
                         {pwm_out_h, pwm_out_l, period_irq, busy}, {e.h, e.l, e.irq, e.busy});
            end
            drive(s); tick();
        end
    endtask

    task automatic test_oneshot();
        setup(2'b11, 1'b0, 8'd0, 8'd0);
        for (int c = 0; c < 30; c++) begin
            stim_q.push_back(stim_t'{m0: (c == 5) || (c == 14) || (c == 25), m1: (c == 16) || (c == 25),
                                     ovf: c == 9, arm: (c == 2) || (c == 22), en: 1'b1});
            exp_q.push_back(exp_t'{h: (c >= 7) && (c <= 10), l: (c < 7) || (c > 10),
                                   irq: (c == 11) || (c == 27),
                                   busy: ((c >= 3) && (c <= 9)) || ((c >= 23) && (c <= 25)), skip: 1'b0});
        end
        for (int c = 0; exp_q.size() != 0; c++) begin
            exp_t e; stim_t s;
            e = exp_q.pop_front(); s = stim_q.pop_front();
            checks++;
            if ({pwm_out_h, pwm_out_l, period_irq, busy} !== {e.h, e.l, e.irq, e.busy}) begin
                failures++;
                $display("FAIL oneshot cyc=%0d h,l,irq,busy got=%b exp=%b", c,
                         {pwm_out_h, pwm_out_l, period_irq, busy}, {e.h, e.l, e.irq, e.busy});
            end
            drive(s); tick();
        end
    endtask

    // en dropped while h is high; the later IRQ timing proves ps_cnt was cleared.
    task automatic test_en_drop();
        setup(2'b01, 1'b0, 8'd0, 8'd1);
        for (int c = 0; c < 23; c++) begin
            stim_q.push_back(stim_t'{m0: (c == 3) || (c == 15) || (c == 18), m1: 1'b0, ovf: 1'b0, arm: 1'b0,
                                     en: (c < 8) || (c > 11)});
            exp_q.push_back(exp_t'{h: ((c >= 5) && (c <= 8)) || (c >= 17),
                                   l: (c < 5) || ((c >= 13) && (c <= 16)),
                                   irq: c == 20, busy: 1'b0, skip: c == 9});
        end
        for (int c = 0; exp_q.size() != 0; c++) begin
            exp_t e; stim_t s;
            e = exp_q.pop_front(); s = stim_q.pop_front();
            if (!e.skip) begin
                checks++;
                if ({pwm_out_h, pwm_out_l, period_irq, busy} !== {e.h, e.l, e.irq, e.busy}) begin
                    failures++;
                    $display("FAIL en_drop cyc=%0d h,l,irq,busy got=%b exp=%b", c,
                             {pwm_out_h, pwm_out_l, period_irq, busy}, {e.h, e.l, e.irq, e.busy});
                end
            end
            drive(s); tick();
        end
    endtask

    task automatic test_reset_mid_pulse();
        setup(2'b01, 1'b0, 8'd0, 8'd0);
        for (int c = 0; c < 7; c++) begin
            stim_q.push_back(stim_t'{m0: c == 2, m1: 1'b0, ovf: 1'b0, arm: 1'b0, en: 1'b1});
            exp_q.push_back(exp_t'{h: c >= 4, l: c < 4, irq: c == 4, busy: 1'b0, skip: 1'b0});
        end
        for (int c = 0; exp_q.size() != 0; c++) begin
            exp_t e; stim_t s;
            e = exp_q.pop_front(); s = stim_q.pop_front();
            checks++;
            if ({pwm_out_h, pwm_out_l, period_irq, busy} !== {e.h, e.l, e.irq, e.busy}) begin
                failures++;
                $display("FAIL rst_mid_pre cyc=%0d h,l,irq,busy got=%b exp=%b", c,
                         {pwm_out_h, pwm_out_l, period_irq, busy}, {e.h, e.l, e.irq, e.busy});
            end
            drive(s); tick();
        end
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if ({pwm_out_h, pwm_out_l, period_irq, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL rst_mid_async got=%b exp=0000", {pwm_out_h, pwm_out_l, period_irq, busy});
        end
        mode = 2'b11;
        #2 sys_rst_n = 1'b1;
        tick(); tick(); tick();
        // FSM must be IDLE after reset: match0 without arm produces nothing
        for (int c = 0; c < 8; c++) begin
            stim_q.push_back(stim_t'{m0: c == 2, m1: c == 4, ovf: 1'b0, arm: 1'b0, en: 1'b1});
            exp_q.push_back(exp_t'{h: 1'b0, l: 1'b1, irq: 1'b0, busy: 1'b0, skip: 1'b0});
        end
        for (int c = 0; exp_q.size() != 0; c++) begin
            exp_t e; stim_t s;
            e = exp_q.pop_front(); s = stim_q.pop_front();
            checks++;
            if ({pwm_out_h, pwm_out_l, period_irq, busy} !== {e.h, e.l, e.irq, e.busy}) begin
                failures++;
                $display("FAIL rst_mid_post cyc=%0d h,l,irq,busy got=%b exp=%b", c,
                         {pwm_out_h, pwm_out_l, period_irq, busy}, {e.h, e.l, e.irq, e.busy});
            end
            drive(s); tick();
        end
    endtask

    initial begin
        test_reset();
        test_pwm(8'd0);
        test_pwm(8'd3);
        test_polarity_zero_duty();
        test_postscaler();
        test_toggle();
        test_oneshot();
        test_en_drop();
        test_reset_mid_pulse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
